// File: rtl/usb_packet_framer.sv
// rtl/usb_packet_framer.sv - buffers a 16-bit test-data stream and frames it into USB packets
//
// Purpose: accepts words from the acquisition mode switcher into an internal
// FIFO and emits framed packets to the USB slave FIFO:
//   0xEB90, {ModeSelect, Seq[11:0]}, Len payload words, [CRC], {4'hA, Len[11:0]}
// Full packets carry PACKET_WORDS words; a Flush pulse drains whatever is
// buffered as a short packet that is committed with UsbPktEnd.
// Optional feature macro: PACKET_CRC_EN inserts a CRC-16-CCITT word
// (poly 0x1021, init 0xFFFF, MSB first) over the payload before the trailer.
//
// Ports:
//   Clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   ModeSelect    in   [3:0]  acquisition mode, placed in the header
//   InData        in   [15:0] upstream data word
//   InDataEnable  in   upstream write strobe
//   InFifoFull    out  registered almost-full back-pressure
//   Flush         in   pulse requesting a short-packet flush
//   UsbFull       in   USB slave FIFO full flag
//   UsbData       out  [15:0] registered word to the USB FIFO
//   UsbWrite      out  registered write strobe
//   UsbPktEnd     out  one-cycle short-packet commit pulse
//   PacketCount   out  [15:0] completed packets, wrapping
//   Overflow      out  sticky: a word was dropped on a full FIFO
module usb_packet_framer #(
  parameter int FIFO_DEPTH         = 1024,
  parameter int PACKET_WORDS       = 256,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [3:0]  ModeSelect,
  input  logic [15:0] InData,
  input  logic        InDataEnable,
  output logic        InFifoFull,
  input  logic        Flush,
  input  logic        UsbFull,
  output logic [15:0] UsbData,
  output logic        UsbWrite,
  output logic        UsbPktEnd,
  output logic [15:0] PacketCount,
  output logic        Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAY,
`ifdef PACKET_CRC_EN
    S_CRC,
`endif
    S_TRL,
    S_END,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and pointers
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // packet context
  logic [11:0] len_q, len_d;
  logic        short_q, short_d;
  logic [11:0] pay_cnt_q, pay_cnt_d;
  logic [11:0] seq_q;
  logic        pend_q, pend_clr;
  logic        issue;
  logic [15:0] issue_word;
  logic        pkt_end_d;
  logic        done;

`ifdef PACKET_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign push = InDataEnable && (count_q != CW'(FIFO_DEPTH));

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= InData;
  end

  // Next-state and issue logic. A word is issued only when UsbFull is low;
  // otherwise the state holds.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_word = 16'h0000;
    pop        = 1'b0;
    len_d      = len_q;
    short_d    = short_q;
    pay_cnt_d  = pay_cnt_q;
    pend_clr   = 1'b0;
    pkt_end_d  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        pay_cnt_d = 12'd0;
        if (32'(count_q) >= 32'(PACKET_WORDS)) begin
          len_d   = 12'(PACKET_WORDS);
          short_d = 1'b0;
          state_d = S_HDR0;
        end else if (pend_q && count_q != '0) begin
          len_d   = 12'(count_q);
          short_d = 1'b1;
          state_d = S_HDR0;
        end else if (pend_q) begin
          pend_clr = 1'b1;
        end
      end
      S_HDR0: begin
        if (!UsbFull) begin
          issue      = 1'b1;
          issue_word = 16'hEB90;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (!UsbFull) begin
          issue      = 1'b1;
          issue_word = {ModeSelect, seq_q};
          state_d    = S_PAY;
        end
      end
      S_PAY: begin
        if (!UsbFull) begin
          issue      = 1'b1;
          issue_word = mem[rd_ptr];
          pop        = 1'b1;
          pay_cnt_d  = pay_cnt_q + 12'd1;
          if (pay_cnt_q == len_q - 12'd1) begin
`ifdef PACKET_CRC_EN
            state_d = S_CRC;
`else
            state_d = S_TRL;
`endif
          end
        end
      end
`ifdef PACKET_CRC_EN
      S_CRC: begin
        if (!UsbFull) begin
          issue      = 1'b1;
          issue_word = crc_q;
          state_d    = S_TRL;
        end
      end
`endif
      S_TRL: begin
        if (!UsbFull) begin
          issue      = 1'b1;
          issue_word = {4'hA, len_q};
          state_d    = short_q ? S_END : S_DONE;
        end
      end
      S_END: begin
        pkt_end_d = 1'b1;
        // data that arrived during the packet keeps the flush alive
        if (count_q == '0) pend_clr = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      len_q       <= 12'd0;
      short_q     <= 1'b0;
      pay_cnt_q   <= 12'd0;
      seq_q       <= 12'd0;
      pend_q      <= 1'b0;
      UsbData     <= 16'h0000;
      UsbWrite    <= 1'b0;
      UsbPktEnd   <= 1'b0;
      PacketCount <= 16'h0000;
      Overflow    <= 1'b0;
      InFifoFull  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      short_q   <= short_d;
      pay_cnt_q <= pay_cnt_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (InDataEnable && !push) Overflow <= 1'b1;
      // registered from the post-update count so the flag tracks the level
      InFifoFull <= (32'(FIFO_DEPTH) - 32'(count_d)) <= 32'(ALMOST_FULL_MARGIN);
      // a Flush seen while already pending is absorbed
      pend_q    <= pend_clr ? 1'b0 : (pend_q | Flush);
      UsbWrite  <= issue;
      if (issue) UsbData <= issue_word;
      UsbPktEnd <= pkt_end_d;
      if (done) begin
        seq_q       <= seq_q + 12'd1;
        PacketCount <= PacketCount + 16'd1;
      end
    end
  end

`ifdef PACKET_CRC_EN
  always_ff @(posedge Clk) begin
    if (reset || state_q == S_HDR0) crc_q <= 16'hFFFF;
    else if (pop)                   crc_q <= crc16_step(crc_q, issue_word);
  end
`endif

endmodule

// File: tb/tb_usb_packet_framer.sv
// tb/tb_usb_packet_framer.sv - self-checking bench for usb_packet_framer
module tb_usb_packet_framer;

  logic        Clk = 1'b0;
  logic        reset;
  logic [3:0]  ModeSelect;
  logic [15:0] InData;
  logic        InDataEnable;
  logic        InFifoFull;
  logic        Flush;
  logic        UsbFull;
  logic [15:0] UsbData;
  logic        UsbWrite;
  logic        UsbPktEnd;
  logic [15:0] PacketCount;
  logic        Overflow;

  always #5 Clk = ~Clk;

  usb_packet_framer #(
    .FIFO_DEPTH(16),
    .PACKET_WORDS(4),
    .ALMOST_FULL_MARGIN(4)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .ModeSelect(ModeSelect),
    .InData(InData),
    .InDataEnable(InDataEnable),
    .InFifoFull(InFifoFull),
    .Flush(Flush),
    .UsbFull(UsbFull),
    .UsbData(UsbData),
    .UsbWrite(UsbWrite),
    .UsbPktEnd(UsbPktEnd),
    .PacketCount(PacketCount),
    .Overflow(Overflow)
  );

  typedef struct {
    logic [15:0] data;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t        vt[20];
  logic [15:0] sb[$];
  logic [15:0] mfifo[$];
  int          checks = 0;
  int          errors = 0;
  int          write_count = 0;
  int          pktend_seen = 0;
  int          pktend_exp = 0;
  int          cyc = 0;
  int          last_write_cyc = -10;
  logic [15:0] last_word = 16'h0000;
  logic [15:0] mon_exp;
  logic [11:0] seq_m = 12'd0;
  logic [15:0] pc_m = 16'd0;
  int          base;
  int          pe_base;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Output monitor: every USB write is popped against the scoreboard.
  always @(negedge Clk) begin
    cyc++;
    if (UsbWrite === 1'b1) begin
      write_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL usb_write_unexpected got=%h expected=none", UsbData);
      end else begin
        mon_exp = sb.pop_front();
        if (UsbData !== mon_exp) begin
          errors++;
          $display("FAIL usb_data got=%h expected=%h", UsbData, mon_exp);
        end
      end
      last_word      = UsbData;
      last_write_cyc = cyc;
    end
    if (UsbPktEnd === 1'b1) begin
      pktend_seen++;
      checks++;
      if (!(last_write_cyc == cyc - 1 && last_word[15:12] == 4'hA)) begin
        errors++;
        $display("FAIL pktend_after_trailer got_last_word=%h got_gap=%0d expected=Axxx gap 1",
                 last_word, cyc - last_write_cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    InData       = d;
    InDataEnable = 1'b1;
    if (mfifo.size() < 16) mfifo.push_back(d);
    tick();
    InDataEnable = 1'b0;
  endtask

  // Expected words of one packet built from the model FIFO.
  task automatic model_packet(input int len, input bit short_pkt);
    logic [15:0] w;
    logic [15:0] crc;
    crc = 16'hFFFF;
    sb.push_back(16'hEB90);
    sb.push_back({ModeSelect, seq_m});
    for (int i = 0; i < len; i++) begin
      w = mfifo.pop_front();
      sb.push_back(w);
      crc = crc_step(crc, w);
    end
`ifdef PACKET_CRC_EN
    sb.push_back(crc);
`endif
    sb.push_back({4'hA, 12'(len)});
    if (short_pkt) pktend_exp++;
    seq_m = seq_m + 12'd1;
    pc_m  = pc_m + 16'd1;
  endtask

  task automatic wait_pc(input logic [15:0] target, input string name);
    for (int i = 0; i < 400; i++) begin
      if (PacketCount === target) break;
      @(negedge Clk);
    end
    check(name, PacketCount, target);
    tick();
  endtask

  task automatic wait_writes(input int target, input string name);
    for (int i = 0; i < 200; i++) begin
      if (write_count >= target) break;
      @(negedge Clk);
    end
    check(name, write_count >= target, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_usb_write"}, UsbWrite, 0);
    check({tag, "_usb_data"}, UsbData, 0);
    check({tag, "_pkt_end"}, UsbPktEnd, 0);
    check({tag, "_packet_count"}, PacketCount, 0);
    check({tag, "_overflow"}, Overflow, 0);
    check({tag, "_in_fifo_full"}, InFifoFull, 0);
  endtask

  initial begin
    reset        = 1'b1;
    ModeSelect   = 4'd3;
    InData       = 16'h0000;
    InDataEnable = 1'b0;
    Flush        = 1'b0;
    UsbFull      = 1'b0;
    for (int i = 0; i < 20; i++)
      vt[i] = '{16'h0200 + 16'(i), (i + 1) >= 12, (i + 1) >= 17};

    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // full packet
    for (int i = 1; i <= 4; i++) push(16'(i));
    model_packet(4, 1'b0);
    wait_pc(pc_m, "pc_full_packet");
    check("no_pktend_full_packet", pktend_seen, 0);
    check("sb_empty_full_packet", sb.size(), 0);

    // flushed short packet
    push(16'h0011);
    push(16'h0022);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    model_packet(2, 1'b1);
    wait_pc(pc_m, "pc_short_packet");
    check("pktend_count_short", pktend_seen, pktend_exp);
    check("sb_empty_short", sb.size(), 0);
    push(16'h0101);
    base = write_count;
    repeat (20) tick();
    check("flush_pending_cleared", write_count, base);

    // stall mid-payload
    base = write_count;
    for (int i = 2; i <= 4; i++) push(16'h0100 + 16'(i));
    model_packet(4, 1'b0);
    wait_writes(base + 3, "reach_payload");
    tick();
    UsbFull = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("no_write_during_stall", UsbWrite, 0);
    end
    tick();
    UsbFull = 1'b0;
    wait_pc(pc_m, "pc_after_stall");
    check("sb_empty_stall", sb.size(), 0);

    // fill and overflow with the USB side blocked
    UsbFull = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      push(vt[i].data);
      check($sformatf("in_fifo_full_%0d", i + 1), InFifoFull, vt[i].exp_full);
      check($sformatf("overflow_%0d", i + 1), Overflow, vt[i].exp_ovf);
    end
    for (int p = 0; p < 4; p++) model_packet(4, 1'b0);
    UsbFull = 1'b0;
    wait_pc(pc_m, "pc_after_drain");
    check("in_fifo_full_drained", InFifoFull, 0);
    check("overflow_sticky", Overflow, 1);
    check("sb_empty_drain", sb.size(), 0);

    // reset in the middle of a payload
    base = write_count;
    for (int i = 1; i <= 4; i++) push(16'h0300 + 16'(i));
    model_packet(4, 1'b0);
    wait_writes(base + 3, "reach_payload_reset");
    tick();
    reset = 1'b1;
    tick();
    sb.delete();
    mfifo.delete();
    seq_m = 12'd0;
    pc_m  = 16'd0;
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    tick();
    base    = write_count;
    pe_base = pktend_seen;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    repeat (20) tick();
    check("empty_flush_no_write", write_count, base);
    check("empty_flush_no_pktend", pktend_seen, pe_base);
    check("empty_flush_packet_count", PacketCount, 0);
    push(16'h0401);
    repeat (20) tick();
    check("empty_flush_pending_cleared", write_count, base);
    for (int i = 2; i <= 4; i++) push(16'h0400 + 16'(i));
    model_packet(4, 1'b0);
    wait_pc(pc_m, "pc_after_reset");
    check("sb_empty_after_reset", sb.size(), 0);
    check("pktend_total", pktend_seen, pktend_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
